alu_functions: RTL and testbench
================================

// Module: alu_functions
// PURPOSE
//  Parallel ALU function unit for the Janus datapath: evaluates every ALU operation on
//  operands inp_a/inp_b at once, registers all results plus NZCV flags, and leaves
//  result selection to the downstream ALU mux. One clock, one cycle of latency.
// PARAMETERS
//  WIDTH    32   operand/result width (>=8, power of two)
//  SHW      5    shift-amount width = $clog2(WIDTH); shifts use inp_b[SHW-1:0]
// PORTS
//  clk      in   1      clock; all state updates on rising edge
//  rst_n    in   1      reset, asynchronous, active-low
//  in_valid in   1      operands valid this cycle
//  inp_a    in   WIDTH  operand A
//  inp_b    in   WIDTH  operand B (also shift amount source)
//  out_valid out 1      registered results correspond to an accepted operand pair
//  add_out  out  WIDTH  A + B (mod 2^WIDTH)
//  sub_out  out  WIDTH  A - B (mod 2^WIDTH)
//  and_out  out  WIDTH  A & B
//  or_out   out  WIDTH  A | B
//  xor_out  out  WIDTH  A ^ B
//  sfl_out  out  WIDTH  A << B[SHW-1:0], zero fill
//  sfr_out  out  WIDTH  A >> B[SHW-1:0], logical, zero fill
//  chk_out  out  WIDTH  signed compare: {WIDTH-1 zeros, ($signed(A) < $signed(B))}
//  cf       out  1      carry of A + ~B + 1 (1 = no borrow, i.e. A >= B unsigned)
//  nf       out  1      sub_out[WIDTH-1]
//  zf       out  1      sub_out == 0
//  vf       out  1      signed overflow of A - B: (A[msb]!=B[msb]) & (sub[msb]!=A[msb])
// BEHAVIOUR
//  - Reset (rst_n=0, async): all outputs, including out_valid, flags and results, go to 0
//    immediately and hold until the first rising clk edge after rst_n deasserts.
//  - Latency 1: the edge that samples in_valid=1 loads all result/flag registers from
//    that inp_a/inp_b and sets out_valid=1.
//  - in_valid=0 at an edge: result/flag registers hold previous values; out_valid=0.
//  - No backpressure; a new operand pair may be accepted every cycle.
//  - Flags always describe the subtraction A - B (compare semantics); add_out carry is
//    not exported.
//  - Arithmetic wraps modulo 2^WIDTH; no saturation.
//  - Shift amount uses only the low SHW bits of B; upper bits ignored (B=32 -> shift 0).
//  - Shift amount 0 returns A unchanged on both shifters.
//  - Reset asserted mid-stream discards the in-flight result; out_valid=0 on release.
// STRUCTURE
//  - Shared package alu_pkg: WIDTH default, SHW derivation, flag bit index constants
//    (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0) for the downstream status register.
//  - One combinational sub-module alu_fn_comb (all operations + flags); the top
//    registers its outputs. Single WIDTH+1 adder computes sub/cf/vf.
// TESTING
//  - A=0x4, B=0xA, in_valid=1 -> next cycle add=0xE, sub=0xFFFFFFFA, and=0, or=0xE,
//    xor=0xE, sfl=0x1000, sfr=0, chk=1, N=1 Z=0 C=0 V=0, out_valid=1.
//  - A=B=0x12345678 -> sub=0, Z=1, C=1, N=0, V=0, chk=0, xor=0.
//  - A=0x7FFFFFFF, B=0xFFFFFFFF -> add=0x7FFFFFFE, sub=0x80000000, V=1, N=1, C=0, chk=0.
//  - A=0x80000001, B=0x21 -> sfl=0x00000002, sfr=0x40000000 (shift 1); B=0x20 -> both = A.
//  - Drive valid operands, pull rst_n low between edges -> all outputs 0 without a clock
//    edge; release -> outputs stay 0 until the next accepted in_valid.
//  - in_valid toggling 1,0,1 with changing operands -> results update only on accepted
//    cycles, out_valid mirrors in_valid delayed by one cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the Janus ALU function unit.
//   WIDTH_DEF : default operand/result width
//   SHW_DEF   : shift-amount width derived from WIDTH_DEF
//   FLAG_*    : bit positions of N/Z/C/V in the downstream status register
package alu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SHW_DEF   = $clog2(WIDTH_DEF);

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FLAG_CNT = 4;

endpackage

// File: rtl/alu_fn_comb.sv
// Combinational core of the ALU function unit: every operation on a/b in parallel,
// plus NZCV flags that always describe the subtraction a - b.
// Ports:
//   a, b                 : operands (b also supplies the shift amount in its low SHW bits)
//   add_res .. sfr_res   : arithmetic, logic and shift results
//   chk_res              : 1 when a < b as signed numbers, zero-extended
//   nzcv                 : flags indexed by FLAG_N/FLAG_Z/FLAG_C/FLAG_V
module alu_fn_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic [WIDTH-1:0]    add_res,
    output logic [WIDTH-1:0]    sub_res,
    output logic [WIDTH-1:0]    and_res,
    output logic [WIDTH-1:0]    or_res,
    output logic [WIDTH-1:0]    xor_res,
    output logic [WIDTH-1:0]    sfl_res,
    output logic [WIDTH-1:0]    sfr_res,
    output logic [WIDTH-1:0]    chk_res,
    output logic [FLAG_CNT-1:0] nzcv
);

    localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0]   diff_ext;
    logic [SHW-1:0]   shamt;
    logic             msb_a;
    logic             msb_b;
    logic             msb_d;
    logic             ovf;

    // One WIDTH+1 adder yields the difference and the no-borrow carry together.
    assign diff_ext = {1'b0, a} + {1'b0, ~b} + ONE_EXT;
    assign sub_res  = diff_ext[WIDTH-1:0];

    assign add_res  = a + b;
    assign and_res  = a & b;
    assign or_res   = a | b;
    assign xor_res  = a ^ b;

    // Upper bits of b are ignored, so b == WIDTH shifts by zero.
    assign shamt    = b[SHW-1:0];
    assign sfl_res  = a << shamt;
    assign sfr_res  = a >> shamt;

    assign msb_a    = a[WIDTH-1];
    assign msb_b    = b[WIDTH-1];
    assign msb_d    = diff_ext[WIDTH-1];
    assign ovf      = (msb_a != msb_b) & (msb_d != msb_a);

    // Signed less-than falls out of the subtraction: N xor V.
    assign chk_res  = {{(WIDTH-1){1'b0}}, msb_d ^ ovf};

    always_comb begin
        nzcv         = '0;
        nzcv[FLAG_N] = msb_d;
        nzcv[FLAG_Z] = (sub_res == '0);
        nzcv[FLAG_C] = diff_ext[WIDTH];
        nzcv[FLAG_V] = ovf;
    end

endmodule

// File: rtl/alu_functions.sv
// Parallel ALU function unit: evaluates all operations on inp_a/inp_b every cycle and
// registers results and NZCV flags when in_valid is high. Result selection is left to
// the downstream ALU mux. Latency is one cycle.
// Ports:
//   clk, rst_n        : clock and asynchronous active-low reset
//   in_valid          : operand pair valid this cycle
//   inp_a, inp_b      : operands (inp_b also supplies the shift amount)
//   out_valid         : registered results belong to an accepted operand pair
//   add_out..chk_out  : registered operation results
//   cf, nf, zf, vf    : registered flags of inp_a - inp_b
module alu_functions
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] inp_a,
    input  logic [WIDTH-1:0] inp_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] add_out,
    output logic [WIDTH-1:0] sub_out,
    output logic [WIDTH-1:0] and_out,
    output logic [WIDTH-1:0] or_out,
    output logic [WIDTH-1:0] xor_out,
    output logic [WIDTH-1:0] sfl_out,
    output logic [WIDTH-1:0] sfr_out,
    output logic [WIDTH-1:0] chk_out,
    output logic             cf,
    output logic             nf,
    output logic             zf,
    output logic             vf
);

    logic [WIDTH-1:0]    add_p0;
    logic [WIDTH-1:0]    sub_p0;
    logic [WIDTH-1:0]    and_p0;
    logic [WIDTH-1:0]    or_p0;
    logic [WIDTH-1:0]    xor_p0;
    logic [WIDTH-1:0]    sfl_p0;
    logic [WIDTH-1:0]    sfr_p0;
    logic [WIDTH-1:0]    chk_p0;
    logic [FLAG_CNT-1:0] nzcv_p0;

    alu_fn_comb #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_comb (
        .a       (inp_a),
        .b       (inp_b),
        .add_res (add_p0),
        .sub_res (sub_p0),
        .and_res (and_p0),
        .or_res  (or_p0),
        .xor_res (xor_p0),
        .sfl_res (sfl_p0),
        .sfr_res (sfr_p0),
        .chk_res (chk_p0),
        .nzcv    (nzcv_p0)
    );

    // ---- stage p0 -> p1: result/flag registers ----
    // Results clear on reset (so a mid-stream reset discards the in-flight pair) and
    // otherwise hold while in_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            add_out   <= '0;
            sub_out   <= '0;
            and_out   <= '0;
            or_out    <= '0;
            xor_out   <= '0;
            sfl_out   <= '0;
            sfr_out   <= '0;
            chk_out   <= '0;
            cf        <= 1'b0;
            nf        <= 1'b0;
            zf        <= 1'b0;
            vf        <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                add_out <= add_p0;
                sub_out <= sub_p0;
                and_out <= and_p0;
                or_out  <= or_p0;
                xor_out <= xor_p0;
                sfl_out <= sfl_p0;
                sfr_out <= sfr_p0;
                chk_out <= chk_p0;
                cf      <= nzcv_p0[FLAG_C];
                nf      <= nzcv_p0[FLAG_N];
                zf      <= nzcv_p0[FLAG_Z];
                vf      <= nzcv_p0[FLAG_V];
            end
        end
    end

endmodule

// File: tb/tb_alu_functions.sv
// Self-checking bench for alu_functions: directed cases, reset behaviour and
// randomized operands against a behavioural reference model.
module tb_alu_functions;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  inp_a;
    logic [W-1:0]  inp_b;
    logic          out_valid;
    logic [W-1:0]  add_out, sub_out, and_out, or_out, xor_out, sfl_out, sfr_out, chk_out;
    logic          cf, nf, zf, vf;

    // reference model state
    logic          e_valid;
    logic [W-1:0]  e_add, e_sub, e_and, e_or, e_xor, e_sfl, e_sfr, e_chk;
    logic          e_cf, e_nf, e_zf, e_vf;

    int n_tests;
    int n_fail;

    alu_functions #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inp_a     (inp_a),
        .inp_b     (inp_b),
        .out_valid (out_valid),
        .add_out   (add_out),
        .sub_out   (sub_out),
        .and_out   (and_out),
        .or_out    (or_out),
        .xor_out   (xor_out),
        .sfl_out   (sfl_out),
        .sfr_out   (sfr_out),
        .chk_out   (chk_out),
        .cf        (cf),
        .nf        (nf),
        .zf        (zf),
        .vf        (vf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_valid = 1'b0;
        e_add = '0; e_sub = '0; e_and = '0; e_or = '0; e_xor = '0;
        e_sfl = '0; e_sfr = '0; e_chk = '0;
        e_cf = 1'b0; e_nf = 1'b0; e_zf = 1'b0; e_vf = 1'b0;
    endtask

    // Arithmetic computed in 64-bit integers from the operation definitions.
    task automatic model_step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        longint ua, ub, sa, sb, sd, ud;
        int sh;
        e_valid = v;
        if (v) begin
            ua = longint'({32'd0, a});
            ub = longint'({32'd0, b});
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sd = sa - sb;
            ud = (ua - ub) & 64'hFFFF_FFFF;
            sh = int'(ub % 32);
            e_add = W'((ua + ub) & 64'hFFFF_FFFF);
            e_sub = W'(ud);
            e_and = a & b;
            e_or  = a | b;
            e_xor = a ^ b;
            e_sfl = W'((ua << sh) & 64'hFFFF_FFFF);
            e_sfr = W'(ua >> sh);
            e_chk = (sa < sb) ? 32'd1 : 32'd0;
            e_cf  = (ua >= ub);
            e_nf  = (ud >= 64'h8000_0000);
            e_zf  = (ud == 0);
            e_vf  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".vld"}, W'(out_valid), W'(e_valid));
        check({tag, ".add"}, add_out, e_add);
        check({tag, ".sub"}, sub_out, e_sub);
        check({tag, ".and"}, and_out, e_and);
        check({tag, ".or"},  or_out,  e_or);
        check({tag, ".xor"}, xor_out, e_xor);
        check({tag, ".sfl"}, sfl_out, e_sfl);
        check({tag, ".sfr"}, sfr_out, e_sfr);
        check({tag, ".chk"}, chk_out, e_chk);
        check({tag, ".cf"},  W'(cf), W'(e_cf));
        check({tag, ".nf"},  W'(nf), W'(e_nf));
        check({tag, ".zf"},  W'(zf), W'(e_zf));
        check({tag, ".vf"},  W'(vf), W'(e_vf));
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag);
        @(negedge clk);
        in_valid = v;
        inp_a    = a;
        inp_b    = b;
        @(posedge clk);
        model_step(v, a, b);
        #1;
        check_all(tag);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        inp_a    = '0;
        inp_b    = '0;
        model_reset();

        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset");

        // Directed cases with literal expectations.
        cycle(1'b1, 32'h4, 32'hA, "d4_a");
        check("lit.sub", sub_out, 32'hFFFF_FFFA);
        check("lit.sfl", sfl_out, 32'h0000_1000);
        check("lit.chk", chk_out, 32'h1);
        cycle(1'b1, 32'h1234_5678, 32'h1234_5678, "eq");
        check("lit.zf", W'(zf), 32'h1);
        check("lit.cf", W'(cf), 32'h1);
        cycle(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, "ovf");
        check("lit.add", add_out, 32'h7FFF_FFFE);
        check("lit.vf", W'(vf), 32'h1);
        cycle(1'b1, 32'h8000_0001, 32'h21, "sh1");
        check("lit.sfr", sfr_out, 32'h4000_0000);
        cycle(1'b1, 32'h8000_0001, 32'h20, "sh0");
        check("lit.sfl0", sfl_out, 32'h8000_0001);
        cycle(1'b1, 32'h8000_0000, 32'h1, "minneg");
        cycle(1'b1, 32'h0, 32'h0, "zero");

        // Valid toggling: results hold while in_valid is low.
        cycle(1'b1, 32'hDEAD_BEEF, 32'h0000_0003, "tog1");
        cycle(1'b0, 32'h1111_1111, 32'h2222_2222, "tog0");
        cycle(1'b1, 32'h0F0F_0F0F, 32'hF0F0_F0F0, "tog2");

        // Asynchronous reset between edges while operands stay valid.
        cycle(1'b1, 32'hCAFE_F00D, 32'h0BAD_BEEF, "pre_rst");
        @(negedge clk);
        in_valid = 1'b1;
        inp_a    = 32'h1357_9BDF;
        inp_b    = 32'h2468_ACE0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all("rst_release");

        // Randomized operands and valid pattern.
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] ra, rb;
            logic rv;
            ra = $urandom;
            rb = $urandom;
            rv = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: rb = W'($urandom_range(0, 63));
                2: ra = 32'h8000_0000;
                3: ra = 32'h7FFF_FFFF;
                default: ;
            endcase
            cycle(rv, ra, rb, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
